// File: rtl/operand2_shifter_pipe.sv
// operand2_shifter_pipe: two-stage ARM-exact operand-2 barrel shifter with valid/ready handshakes.
module operand2_shifter_pipe #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = $clog2(DATA_W),
  parameter int ROT_W  = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic              reg_shift,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [ROT_W-1:0]  rot,
  input  logic [1:0]        sh,
  input  logic [23:0]       imm,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src2,
  output logic              carry_out,
  output logic              was_shifted
);
  typedef enum logic [1:0] {OP_PASS, OP_RRX, OP_SHIFT} op_e;
  localparam logic [7:0] N8 = 8'(DATA_W);
  logic              va_q, va_d, vb_q, vb_d;
  op_e               op_q, op_d, dec_op;
  logic [DATA_W-1:0] val_q, val_d, dec_val;
  logic [7:0]        n_q, n_d, dec_n, n_raw;
  logic [1:0]        sh_q, sh_d, dec_sh;
  logic              cin_q, cin_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic              c_q, c_d, ws_q, ws_d;
  logic              ready_a, ready_b, reg_mode;
  logic [DATA_W:0]   lsl_w, lsr_w, asr_w;
  logic [AMT_W-1:0]  k;
  logic [8:0]        rk;
  logic [DATA_W-1:0] ror_v, sh_res, res;
  logic              sh_c, c_res;
  logic              unused_rs;
  always_comb begin
    unused_rs = ^rs;
    ready_b   = !vb_q || out_ready;
    ready_a   = !va_q || ready_b;
    in_ready  = ready_a;
    reg_mode  = mode == 3'b000 && reg_shift;
    n_raw     = reg_mode ? rs[7:0] : 8'(shamt);
    dec_op    = OP_PASS;
    dec_val   = '0;
    dec_n     = n_raw;
    dec_sh    = sh;
    if (mode == 3'b000 || mode == 3'b011) begin
      // Immediate #0 re-encodes: LSR/ASR #0 mean a full-width shift, ROR #0 means RRX.
      dec_val = rm;
      dec_n   = n_raw == 8'd0 ? N8 : n_raw;
      dec_op  = n_raw != 8'd0 ? OP_SHIFT :
                reg_mode ? OP_PASS :
                sh == 2'b11 ? OP_RRX :
                sh != 2'b00 ? OP_SHIFT : OP_PASS;
    end else if (mode == 3'b001) begin
      dec_val = DATA_W'(imm[7:0]);
      dec_n   = 8'({rot, 1'b0});
      dec_sh  = 2'b11;
      dec_op  = rot != '0 ? OP_SHIFT : OP_PASS;
    end else if (mode == 3'b010) begin
      dec_val = DATA_W'(imm[11:0]);
    end else if (mode == 3'b101) begin
      dec_val = DATA_W'($signed({imm, 2'b00}));
    end
    va_d  = ready_a ? in_valid : va_q;
    op_d  = in_valid && ready_a ? dec_op : op_q;
    val_d = in_valid && ready_a ? dec_val : val_q;
    n_d   = in_valid && ready_a ? dec_n : n_q;
    sh_d  = in_valid && ready_a ? dec_sh : sh_q;
    cin_d = in_valid && ready_a ? carry_in : cin_q;
    // One guard bit beside the operand captures the last bit shifted out, covering n >= N too.
    lsl_w  = {1'b0, val_q} << n_q;
    lsr_w  = {val_q, 1'b0} >> n_q;
    asr_w  = $signed({val_q, 1'b0}) >>> n_q;
    k      = n_q[AMT_W-1:0];
    rk     = 9'(DATA_W) - 9'(k);
    ror_v  = (val_q >> k) | (val_q << rk);
    sh_res = sh_q == 2'b00 ? lsl_w[DATA_W-1:0] :
             sh_q == 2'b01 ? lsr_w[DATA_W:1] :
             sh_q == 2'b10 ? asr_w[DATA_W:1] : ror_v;
    sh_c   = sh_q == 2'b00 ? lsl_w[DATA_W] :
             sh_q == 2'b01 ? lsr_w[0] :
             sh_q == 2'b10 ? asr_w[0] : ror_v[DATA_W-1];
    res    = op_q == OP_SHIFT ? sh_res : op_q == OP_RRX ? {cin_q, val_q[DATA_W-1:1]} : val_q;
    c_res  = op_q == OP_SHIFT ? sh_c : op_q == OP_RRX ? val_q[0] : cin_q;
    vb_d   = ready_b ? va_q : vb_q;
    src2_d = ready_b && va_q ? res : src2_q;
    c_d    = ready_b && va_q ? c_res : c_q;
    ws_d   = ready_b && va_q ? op_q != OP_PASS : ws_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      va_q   <= 1'b0;
      op_q   <= OP_PASS;
      val_q  <= '0;
      n_q    <= '0;
      sh_q   <= '0;
      cin_q  <= 1'b0;
      vb_q   <= 1'b0;
      src2_q <= '0;
      c_q    <= 1'b0;
      ws_q   <= 1'b0;
    end else begin
      va_q   <= va_d;
      op_q   <= op_d;
      val_q  <= val_d;
      n_q    <= n_d;
      sh_q   <= sh_d;
      cin_q  <= cin_d;
      vb_q   <= vb_d;
      src2_q <= src2_d;
      c_q    <= c_d;
      ws_q   <= ws_d;
    end
  end
  assign out_valid   = vb_q;
  assign src2        = src2_q;
  assign carry_out   = c_q;
  assign was_shifted = ws_q;
endmodule
